// File: rtl/nq_mem_pkg.sv
// Shared definitions for the memory arbiter: APB FSM state encoding and
// requester identifiers.
package nq_mem_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_timeout.sv
// Loadable wait-state counter for the APB ACCESS phase; flags expiry on the
// cycle in which the final allowed wait state is being spent.
module arb_timeout #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Expiry is combinational so the abort lands exactly TIMEOUT cycles into ACCESS.
    assign expired = count_en && (count_q == CW'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto a single APB
// master port, with bounded data bursts and an ACCESS-phase timeout.
module mem_arbiter
    import nq_mem_pkg::*;
#(
    parameter int MAX_DM_BURST = 2,
    parameter int TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        apb_valid,
    output logic        busy,
    output logic        err
);

    localparam int SW = (MAX_DM_BURST > 0) ? $clog2(MAX_DM_BURST + 1) : 1;

    logic [1:0]    state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [SW-1:0] dm_streak_q, dm_streak_d;
    logic          if_done_q, if_done_d;
    logic          dm_done_q, dm_done_d;
    logic          err_q, err_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [15:0]   dm_rdata_q, dm_rdata_d;

    logic if_elig, dm_elig, grant_if, grant_dm, done_pending, tmo_expired;

    arb_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == ST_SETUP),
        .count_en((state_q == ST_ACCESS) && !apb_valid),
        .expired (tmo_expired)
    );

    always_comb begin
        if_elig      = if_req && !if_done_q;
        dm_elig      = dm_req && !dm_done_q;
        grant_dm     = dm_elig && !(if_elig && (dm_streak_q == SW'(MAX_DM_BURST)));
        grant_if     = if_elig && !grant_dm;
        // No grant while any done is pulsing, so a held request is never re-served stale.
        done_pending = if_done_q || dm_done_q;

        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        dm_streak_d = dm_streak_q;
        if_done_d   = 1'b0;
        dm_done_d   = 1'b0;
        err_d       = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (!done_pending && (grant_dm || grant_if)) begin
                    state_d = ST_SETUP;
                    owner_d = grant_dm ? OWN_DM : OWN_IF;
                    addr_d  = grant_dm ? dm_addr : if_addr;
                    we_d    = grant_dm && dm_we;
                    wdata_d = grant_dm ? dm_wdata : 16'h0;
                    if (grant_if) begin
                        dm_streak_d = '0;
                    end else if (if_req && (dm_streak_q != SW'(MAX_DM_BURST))) begin
                        dm_streak_d = dm_streak_q + 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb_valid || tmo_expired) begin
                    state_d   = ST_IDLE;
                    if_done_d = (owner_q == OWN_IF);
                    dm_done_d = (owner_q == OWN_DM);
                    err_d     = !apb_valid;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = apb_valid ? prdata : 32'h0;
                    end else begin
                        dm_rdata_d = apb_valid ? prdata[15:0] : 16'h0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            dm_streak_q <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            dm_streak_q <= dm_streak_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            err_q       <= err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign psel     = (state_q != ST_IDLE);
    assign penable  = (state_q == ST_ACCESS);
    assign busy     = (state_q != ST_IDLE);
    assign pwrite   = we_q;
    assign paddr    = addr_q;
    assign pwdata   = {16'h0, wdata_q};
    assign if_done  = if_done_q;
    assign dm_done  = dm_done_q;
    assign err      = err_q;
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_DM_BURST, default 2, meaning max consecutive data grants while fetch is pending.
REQ-002 SHALL have parameter TIMEOUT, default 15, meaning max ACCESS cycles without apb_valid before abort.
REQ-003 SHALL have port clk  input  1  single system clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  fetch request, held until if_done.
REQ-006 SHALL have port if_addr  input  32  fetch word address.
REQ-007 SHALL have port if_rdata  output  32  fetched word, valid with if_done.
REQ-008 SHALL have port if_done  output  1  one-cycle fetch completion pulse.
REQ-009 SHALL have ports dm_req in 1, dm_we in 1, dm_addr in 32 and dm_wdata in 16, meaning data request, write enable, address and write data.
REQ-010 SHALL have ports dm_rdata out 16 and dm_done out 1, meaning read data and one-cycle completion pulse.
REQ-011 SHALL have ports psel out 1, penable out 1, pwrite out 1, paddr out 32 and pwdata out 32, meaning the APB master side.
REQ-012 SHALL have ports prdata in 32 and apb_valid in 1, meaning slave read data and ready.
REQ-013 SHALL have ports busy out 1 (state != IDLE) and err out 1 (timeout pulse, aligned with done).

Function
REQ-014 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; SETUP: psel=1, penable=0; ACCESS: psel=1, penable=1.
REQ-015 In IDLE with an eligible request, SHALL latch grant owner, address, we and wdata, then enter SETUP next cycle.
REQ-016 SHALL drive paddr/pwrite/pwdata from latched values only; pwdata = {16'h0, dm_wdata}; pwrite=0 for fetch.
REQ-017 ACCESS SHALL hold until apb_valid is sampled high, then return to IDLE.
REQ-018 On the cycle after valid, SHALL pulse the owner's done for one cycle with registered rdata (if_rdata=prdata; dm_rdata=prdata[15:0]).
REQ-019 Minimum latency: req at IDLE cycle N, valid at N+2 -> done at N+3.
REQ-020 Priority: dm_req wins over if_req unless dm_streak == MAX_DM_BURST, in which case fetch wins.
REQ-021 dm_streak SHALL increment on each DM grant while if_req is high, clear on any IF grant, saturate at MAX_DM_BURST.
REQ-022 A requester whose done is high in the current cycle SHALL NOT be eligible for grant that cycle.
REQ-023 Request deassertion mid-transaction SHALL be ignored; the transaction completes and done still pulses.
REQ-024 Timeout counter SHALL clear on SETUP and count ACCESS cycles with apb_valid low.
REQ-025 On reaching TIMEOUT, SHALL abort: return to IDLE, done pulse with err=1, rdata=0.
REQ-026 apb_valid outside ACCESS SHALL be ignored.

Reset
REQ-027 On rst, SHALL go to IDLE and zero all outputs, dm_streak and timeout count next edge.
REQ-028 Reset mid-transaction SHALL drop psel/penable next edge with no done or err pulse.

Structure
REQ-029 Shared package nq_mem_pkg SHALL hold the FSM state encoding and requester IDs (OWN_IF, OWN_DM).
REQ-030 Sub-module arb_timeout (loadable counter, expiry flag) SHALL implement REQ-024/025.

Verification
REQ-031 Fetch only: if_req, if_addr=0x10, valid at 3rd cycle, prdata=0xDEADBEEF -> if_done one cycle, if_rdata=0xDEADBEEF, psel/penable sequence 10,11.
REQ-032 Simultaneous: both requesting, dm_we=1, dm_addr=0x200, dm_wdata=0x1234 -> DM first, pwdata=0x00001234, pwrite=1; then IF.
REQ-033 Starvation: dm_req and if_req held high -> grants DM, DM, IF, DM, DM, IF.
REQ-034 Timeout: apb_valid never asserted -> after 15 ACCESS cycles done and err pulse together, rdata=0, busy low next cycle.
REQ-035 Reset in ACCESS -> psel=penable=0 next edge, no done; fresh fetch afterwards completes normally.
